// File: rtl/spi_txn_arbiter_if.sv
// Requester-side bundle of the SPI transaction arbiter: level requests with their
// latched config/data on one side, completion pulse and status on the other.
interface spi_txn_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*6-1:0]  req_cfg;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ-1:0]    ack;
    logic                  err;
    logic [31:0]           rx_data;
    logic [2:0]            grant_id;
    logic                  busy;

    modport master (
        output req, req_cfg, req_data,
        input  ack, err, rx_data, grant_id, busy
    );

    modport slave (
        input  req, req_cfg, req_data,
        output ack, err, rx_data, grant_id, busy
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin scheduler sharing one SPI control/shift datapath among NUM_REQ requesters.
// Sequences FRAME_START -> START -> done for the winner and returns the RX word with an ack pulse.
module spi_txn_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk_cpu,
    input  logic               rst,
    spi_txn_arbiter_if.slave   bus,
    output logic [8:0]         spi_ctrl,
    output logic [31:0]        spi_data_out,
    input  logic               spi_done,
    input  logic [31:0]        spi_data_in
);

    if ((NUM_REQ < 2) || (NUM_REQ > 8) || (SETUP_CYC < 1)) begin : g_bad_params
        $error("spi_txn_arbiter: NUM_REQ must be 2..8 and SETUP_CYC >= 1");
    end

    localparam int CNT_MAX = (TIMEOUT_CYC > SETUP_CYC) ? TIMEOUT_CYC : SETUP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
    localparam logic [2:0]       LAST_ID      = 3'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_START = 3'd2,
        ST_BUSY  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         cfg_q, cfg_d;
    logic [31:0]        data_q, data_d;
    logic [2:0]         grant_q, grant_d;
    logic               busy_q, busy_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               err_q, err_d;
    logic [31:0]        rx_q, rx_d;
    logic [8:0]         spi_ctrl_q, spi_ctrl_d;
    logic               done_q, done_d;

    logic [7:0]         req_pad_s;
    logic [5:0]         cfg_arr_s [8];
    logic [31:0]        data_arr_s [8];
    logic               win_found_s;
    logic [2:0]         win_id_s;
    logic [3:0]         cand_s;
    logic [7:0]         ack_pad_s;
    logic               done_rise_s;

    // Control word layout {ON,MODE,BIT_ORDER,LEN,FRAME_START,START,I_MSK} from a requester cfg.
    function automatic logic [8:0] ctrl_word(input logic [5:0] cfg, input logic start);
        return {1'b1, cfg[5:1], 1'b1, start, cfg[0]};
    endfunction

    // Pad per-requester inputs to 8 slots so 3-bit ids index them without range checks.
    for (genvar g = 0; g < 8; g++) begin : g_pad
        if (g < NUM_REQ) begin : g_used
            assign req_pad_s[g]  = bus.req[g];
            assign cfg_arr_s[g]  = bus.req_cfg[6*g +: 6];
            assign data_arr_s[g] = bus.req_data[32*g +: 32];
        end else begin : g_unused
            assign req_pad_s[g]  = 1'b0;
            assign cfg_arr_s[g]  = 6'd0;
            assign data_arr_s[g] = 32'd0;
        end
    end

    // Round-robin pick: first asserted request scanning upward from ptr, wrapping mod NUM_REQ.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = 3'd0;
        cand_s      = 4'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = {1'b0, ptr_q} + 4'(k);
            if (cand_s >= 4'(NUM_REQ)) begin
                cand_s = cand_s - 4'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!win_found_s && req_pad_s[cand_s[2:0]]) begin
                win_found_s = 1'b1;
                win_id_s    = cand_s[2:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    assign ack_pad_s   = 8'd1 << grant_q;
    assign done_rise_s = spi_done & ~done_q;

    // Transaction sequencer: next-state and registered-output values.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        cfg_d      = cfg_q;
        data_d     = data_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        ack_d      = '0;
        err_d      = 1'b0;
        rx_d       = rx_q;
        spi_ctrl_d = spi_ctrl_q;
        done_d     = spi_done;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d    = ST_SETUP;
                    cfg_d      = cfg_arr_s[win_id_s];
                    data_d     = data_arr_s[win_id_s];
                    grant_d    = win_id_s;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    spi_ctrl_d = ctrl_word(cfg_arr_s[win_id_s], 1'b0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d    = ST_START;
                    cnt_d      = '0;
                    spi_ctrl_d = ctrl_word(cfg_q, 1'b1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_START: begin
                state_d    = ST_BUSY;
                cnt_d      = '0;
                spi_ctrl_d = ctrl_word(cfg_q, 1'b0);
            end
            ST_BUSY: begin
                // A done edge beats a timeout expiring in the same cycle.
                if (done_rise_s) begin
                    state_d    = ST_DONE;
                    ack_d      = ack_pad_s[NUM_REQ-1:0];
                    rx_d       = spi_data_in;
                    spi_ctrl_d = 9'd0;
                end else if ((TIMEOUT_CYC != 0) && (cnt_q == TIMEOUT_LAST)) begin
                    state_d    = ST_DONE;
                    ack_d      = ack_pad_s[NUM_REQ-1:0];
                    err_d      = 1'b1;
                    spi_ctrl_d = 9'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                ptr_d   = (grant_q == LAST_ID) ? 3'd0 : (grant_q + 3'd1);
            end
            default: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                spi_ctrl_d = 9'd0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction without an ack.
    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 3'd0;
            cnt_q      <= '0;
            cfg_q      <= 6'd0;
            data_q     <= 32'd0;
            grant_q    <= 3'd0;
            busy_q     <= 1'b0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            rx_q       <= 32'd0;
            spi_ctrl_q <= 9'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            cfg_q      <= cfg_d;
            data_q     <= data_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rx_q       <= rx_d;
            spi_ctrl_q <= spi_ctrl_d;
            done_q     <= done_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.rx_data  = rx_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = busy_q;
    assign spi_ctrl     = spi_ctrl_q;
    assign spi_data_out = data_q;

endmodule
